key_scan_ctrl: RTL and testbench
================================

Name: key_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad.
- Sequences row drive and column sampling on an internal scan tick derived from clk. No derived clock is generated; the tick is a one-cycle enable.
- Debounces press and release, and reports one key code per debounced press.
- Sits between the keypad pins and the key-consuming logic, e.g. display or digit entry.

Parameters:
TICK_DIV, 2500, clk cycles per scan tick (50 MHz / 2500 = 20 kHz); must be >= 2
DEBOUNCE_TICKS, 200, consecutive stable ticks required for press or release (200 ticks = 10 ms at 20 kHz); must be >= 1
REPEAT_TICKS, 10000, ticks between auto-repeat pulses; used only when KEY_REPEAT_EN is defined

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
col_in  input  4  keypad columns, active-low (pulled up), asynchronous to clk
row_out  output  4  keypad row drive, active-low, exactly one bit low at all times
key_code  output  4  last debounced key, row*4+col
key_valid  output  1  one-clk pulse when key_code is updated
key_pressed  output  1  high from debounced press to debounced release

Behaviour:
- Reset (async, rst_n low) values:
  - row_out=4'b1110, key_code=0, key_valid=0, key_pressed=0.
  - Tick counter=0, debounce counter=0, state=SCAN, synchronizer flops=4'b1111.
- Tick generation:
  - 20-bit counter runs 0..TICK_DIV-1, then wraps to 0.
  - tick=1 for the single clk in which the counter equals TICK_DIV-1.
- Column input: col_in passes through a 2-flop synchronizer; all decisions use the synchronized value col_s.
- All state changes occur only on clk edges where tick=1. The exception is key_valid, which clears on the next clk.
- Row rotation order: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Row index = position of the low bit (0..3).
- SCAN:
  - On tick, if col_s==4'b1111, advance to the next row.
  - If any col_s bit is low, latch row_idx (current row) and col_idx (lowest-numbered low column; lower index wins on multiple presses).
  - Then clear the debounce counter and go to DEBOUNCE. row_out freezes.
- DEBOUNCE:
  - On tick, if col_s[col_idx]==0, increment the counter.
  - When the counter reaches DEBOUNCE_TICKS-1 on a low sample:
    - Update key_code={row_idx,col_idx} (row*4+col).
    - Pulse key_valid for one clk and set key_pressed=1.
    - Go to HOLD.
  - If col_s[col_idx]==1 on a tick (bounce or glitch), return to SCAN and advance the row. No output change.
- HOLD:
  - On tick, if col_s[col_idx]==1, clear the counter and go to RELEASE.
  - Other columns going low are ignored; no rollover.
- RELEASE:
  - On tick, if col_s[col_idx]==1, increment the counter.
  - At DEBOUNCE_TICKS-1, clear key_pressed, advance the row and go to SCAN.
  - If col_s[col_idx]==0 on a tick, return to HOLD. key_pressed stays 1 and there is no new key_valid.
- Latency:
  - Press: from the first tick seeing the key low to key_valid is DEBOUNCE_TICKS ticks, plus 1 clk register delay.
  - The synchronizer adds 2 clk on the input.
- Width rules:
  - The debounce counter is wide enough for max(DEBOUNCE_TICKS, REPEAT_TICKS).
  - key_code is 4 bits, concatenated as {row_idx[1:0], col_idx[1:0]}.
- key_code holds its value after release until the next valid press.
- Reset mid-operation: immediately returns all registers to the reset values, including key_pressed=0 while a key is held. No key_valid is emitted on reset exit.

Optional Feature:
KEY_REPEAT_EN
- Defined:
  - In HOLD, a repeat counter counts ticks from entry to HOLD.
  - At REPEAT_TICKS-1 it pulses key_valid for one clk with the unchanged key_code, then restarts from 0.
  - The repeat counter clears on leaving HOLD, and on returning from RELEASE to HOLD.
- Undefined: exactly one key_valid per debounced press. REPEAT_TICKS is unused and the repeat counter is not built.

Test Plan:
Use TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5 for all scenarios.
1. Reset release, no keys pressed (col_in=1111) -> row_out cycles 1110,1101,1011,0111 with one step per 4 clk; key_valid never asserts; key_code=0.
2. Hold col_in[2]=0 only while row_out=1011 (row 2), stable -> after 3 ticks key_code=4'd10, one 1-clk key_valid, key_pressed=1, row_out frozen at 1011.
3. Press row 1 col 0, then bounce col 0 high for one tick during DEBOUNCE -> no key_valid, return to SCAN, row_out advances to 1011.
4. After a valid press of key 5, release with a one-tick re-closure inside RELEASE, then clean release -> key_pressed stays 1 through the glitch, drops after 3 stable-high ticks; no second key_valid; key_code stays 5.
5. Assert rst_n=0 while in HOLD with key_pressed=1 -> key_pressed=0 and row_out=1110 immediately (asynchronous); after rst_n=1 with the key still held, a fresh debounce produces one new key_valid.
6. With KEY_REPEAT_EN defined, hold key 15 for 20 ticks after debounce -> key_valid pulses at 5-tick intervals (4 pulses) with key_code=15; with it undefined, exactly one pulse.

Source files
------------

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: 4x4 keypad row scanner with press/release debounce.
// Define KEY_REPEAT_EN to emit auto-repeat key_valid pulses while a key is held.
module key_scan_ctrl #(
    parameter int TICK_DIV       = 2500,
    parameter int DEBOUNCE_TICKS = 200,
    parameter int REPEAT_TICKS   = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);
    localparam int CNT_MAX = DEBOUNCE_TICKS > REPEAT_TICKS ? DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [19:0]   tick_cnt_q;
    logic          tick;
    logic [3:0]    sync_q, col_s_q;
    logic [1:0]    row_q, row_d, col_q, col_d, first_low;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d, pressed_q, pressed_d;
    logic          col_hi, rep_fire;

    assign tick      = tick_cnt_q == 20'(TICK_DIV - 1);
    assign col_hi    = col_s_q[col_q];
    assign first_low = !col_s_q[0] ? 2'd0 : !col_s_q[1] ? 2'd1 : !col_s_q[2] ? 2'd2 : 2'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            sync_q     <= '1;
            col_s_q    <= '1;
            state_q    <= SCAN;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 20'd1;
            sync_q     <= col_in;
            col_s_q    <= sync_q;
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = rep_fire;
        pressed_d = pressed_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (&col_s_q) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d   = first_low;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (col_hi) begin
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                        code_d    = {row_q, col_q};
                        valid_d   = 1'b1;
                        pressed_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (col_hi) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!col_hi) begin
                        state_d = HOLD;
                    end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                        pressed_d = 1'b0;
                        row_d     = row_q + 2'd1;
                        state_d   = SCAN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    logic [CW-1:0] rep_q, rep_d;

    // Restarts on every entry to HOLD, including the return from RELEASE.
    always_comb begin
        rep_fire = tick && state_q == HOLD && !col_hi && rep_q == CW'(REPEAT_TICKS - 1);
        rep_d    = (state_q != HOLD || state_d != HOLD) ? '0 : !tick ? rep_q : rep_fire ? '0 : rep_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        row_out     = ~(4'b0001 << row_q);
        key_code    = code_q;
        key_valid   = valid_q;
        key_pressed = pressed_q;
    end
endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed checks of scanning, debounce, release, reset and repeat behaviour.
module tb_key_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in, row_out, key_code;
    logic       key_valid, key_pressed;
    logic       key_on = 1'b0, glitch = 1'b0;
    logic [1:0] kr = 2'd0, kc = 2'd0;
    logic       vprev = 1'b0;
    int         checks = 0, failures = 0, vhigh = 0, vlong = 0, bad_row = 0, tb_cnt = 0, vbase = 0;

    typedef struct packed {
        logic [7:0] ticks;
        logic       on;
        logic [1:0] r, c;
        logic       gl;
        logic [3:0] row, code;
        logic       pr;
        logic [7:0] nv;
    } vec_t;

    vec_t v[18];

    key_scan_ctrl #(.TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
        .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Keypad model: the held key pulls its column low only while its row is driven.
    assign col_in = glitch ? 4'hF : (key_on && !row_out[kr]) ? ~(4'b0001 << kc) : 4'hF;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;

    always @(negedge clk) begin
        if (key_valid) vhigh++;
        if (key_valid && vprev) vlong++;
        vprev = key_valid;
        if (!(row_out inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_row++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick();
        @(posedge clk iff (tb_cnt == 3));
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int t, bit o, int r, int c, bit g, logic [3:0] ro, logic [3:0] co, bit p, int n);
        mk.ticks = 8'(t); mk.on = o; mk.r = 2'(r); mk.c = 2'(c); mk.gl = g;
        mk.row = ro; mk.code = co; mk.pr = p; mk.nv = 8'(n);
    endfunction

    initial begin
        v[0]  = mk(1, 0, 0, 0, 0, 4'b1101, 4'd0,  0, 0);
        v[1]  = mk(1, 0, 0, 0, 0, 4'b1011, 4'd0,  0, 0);
        v[2]  = mk(1, 0, 0, 0, 0, 4'b0111, 4'd0,  0, 0);
        v[3]  = mk(1, 0, 0, 0, 0, 4'b1110, 4'd0,  0, 0);
        v[4]  = mk(2, 1, 2, 2, 0, 4'b1011, 4'd0,  0, 0);
        v[5]  = mk(3, 1, 2, 2, 0, 4'b1011, 4'd0,  0, 0);
        v[6]  = mk(1, 1, 2, 2, 0, 4'b1011, 4'd10, 1, 1);
        v[7]  = mk(2, 1, 2, 2, 0, 4'b1011, 4'd10, 1, 1);
        v[8]  = mk(3, 0, 2, 2, 0, 4'b1011, 4'd10, 1, 1);
        v[9]  = mk(1, 0, 2, 2, 0, 4'b0111, 4'd10, 0, 1);
        v[10] = mk(3, 1, 1, 0, 0, 4'b1101, 4'd10, 0, 1);
        v[11] = mk(1, 0, 1, 0, 1, 4'b1011, 4'd10, 0, 1);
        v[12] = mk(6, 1, 1, 1, 0, 4'b1101, 4'd10, 0, 1);
        v[13] = mk(1, 1, 1, 1, 0, 4'b1101, 4'd5,  1, 2);
        v[14] = mk(1, 0, 1, 1, 0, 4'b1101, 4'd5,  1, 2);
        v[15] = mk(1, 1, 1, 1, 0, 4'b1101, 4'd5,  1, 2);
        v[16] = mk(3, 0, 1, 1, 0, 4'b1101, 4'd5,  1, 2);
        v[17] = mk(1, 0, 1, 1, 0, 4'b1011, 4'd5,  0, 2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_row", row_out, 4'b1110);
        chk("reset_code", key_code, 4'd0);
        chk("reset_valid", key_valid, 1'b0);
        chk("reset_pressed", key_pressed, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            key_on = v[i].on; kr = v[i].r; kc = v[i].c; glitch = v[i].gl;
            repeat (int'(v[i].ticks)) wait_tick();
            chk($sformatf("vec%0d_row", i), row_out, v[i].row);
            chk($sformatf("vec%0d_code", i), key_code, v[i].code);
            chk($sformatf("vec%0d_pressed", i), key_pressed, v[i].pr);
            chk($sformatf("vec%0d_nvalid", i), vhigh, 32'(v[i].nv));
        end
        glitch = 1'b0;

        // Asynchronous reset while a key is held, then a fresh debounce.
        key_on = 1'b1; kr = 2'd2; kc = 2'd3;
        repeat (4) wait_tick();
        chk("hold11_pressed", key_pressed, 1'b1);
        chk("hold11_code", key_code, 4'd11);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_pressed", key_pressed, 1'b0);
        chk("async_row", row_out, 4'b1110);
        chk("async_code", key_code, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vbase = vhigh;
        repeat (5) wait_tick();
        chk("rexit_pressed", key_pressed, 1'b0);
        chk("rexit_novalid", vhigh - vbase, 0);
        wait_tick();
        chk("repress_pressed", key_pressed, 1'b1);
        chk("repress_code", key_code, 4'd11);
        chk("repress_valid", vhigh - vbase, 1);
        key_on = 1'b0;
        repeat (4) wait_tick();
        chk("rerelease_pressed", key_pressed, 1'b0);
        chk("rerelease_row", row_out, 4'b0111);

        // Long hold of key 15: repeat pulses only when the feature is built.
        key_on = 1'b1; kr = 2'd3; kc = 2'd3;
        repeat (4) wait_tick();
        chk("k15_pressed", key_pressed, 1'b1);
        chk("k15_code", key_code, 4'd15);
        vbase = vhigh;
        repeat (4) wait_tick();
        chk("k15_early", vhigh - vbase, 0);
        repeat (16) wait_tick();
`ifdef KEY_REPEAT_EN
        chk("k15_repeats", vhigh - vbase, 4);
`else
        chk("k15_repeats", vhigh - vbase, 0);
`endif
        chk("k15_code_held", key_code, 4'd15);
        key_on = 1'b0;
        chk("valid_one_clk", vlong, 0);
        chk("row_onehot", bad_row, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
